// File: rtl/synch_mod_n_counter_7.sv
// Synchronous modulo-N clock divider. Odd N with DUTY_50 set uses a falling-edge
// copy of the rising-edge phase register to stretch the high phase by half a cycle.
module synch_mod_n_counter_7 #(
  parameter int N       = 7,
  parameter int DUTY_50 = 1,
  parameter int W       = (N < 2) ? 1 : $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  localparam int            H       = N / 2;
  localparam logic [W-1:0]  CNT_MAX = W'(N - 1);
  localparam logic [W-1:0]  H_W     = W'(H);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic         r_pos_q;

  if (N < 2) begin : g_bad_n
    $error("synch_mod_n_counter_7: N must be at least 2");
  end

  always_comb begin
    w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + W'(1);
  end

  // Reset parks the counter at N-1 so the first counting edge wraps to 0 and
  // starts a full-length high phase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt   <= CNT_MAX;
      r_pos_q <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_pos_q <= (w_cnt_nxt < H_W);
    end
  end

  if (((N % 2) == 1) && (DUTY_50 != 0)) begin : g_half_cycle
    logic r_neg_q;

    // neg_q is still 0 when pos_q rises and still 1 when pos_q falls, so the
    // OR output has exactly one rise and one fall per period.
    always_ff @(negedge clk or posedge rst_n) begin
      if (rst_n) begin
        r_neg_q <= 1'b0;
      end else begin
        r_neg_q <= r_pos_q;
      end
    end

    assign clk_out = r_pos_q | r_neg_q;
  end else begin : g_rise_only
    assign clk_out = r_pos_q;
  end

endmodule

// File: tb/tb_synch_mod_n_counter_7.sv
// Scoreboard bench for synch_mod_n_counter_7 across four N / DUTY_50 configurations
// sharing one clock and reset.
module tb_synch_mod_n_counter_7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic co_d7, co_n7, co_e8, co_n2;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;
  int trans = 0;
  int trans_base = 0;
  logic [3:0] sb_q[$];

  synch_mod_n_counter_7 #(.N(7), .DUTY_50(1)) u_d7 (.clk(clk), .rst_n(rst_n), .clk_out(co_d7));
  synch_mod_n_counter_7 #(.N(7), .DUTY_50(0)) u_n7 (.clk(clk), .rst_n(rst_n), .clk_out(co_n7));
  synch_mod_n_counter_7 #(.N(8), .DUTY_50(1)) u_e8 (.clk(clk), .rst_n(rst_n), .clk_out(co_e8));
  synch_mod_n_counter_7 #(.N(2), .DUTY_50(1)) u_n2 (.clk(clk), .rst_n(rst_n), .clk_out(co_n2));

  always #5 clk = ~clk;

  always @(posedge co_d7 or negedge co_d7) trans <= trans + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t (k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  // Reference: k counts rising edges since reset release (0 = in/just out of reset),
  // half = 0 right after a rising edge, 1 right after a falling edge.
  function automatic logic model(int n, bit duty, int kk, bit half);
    int h;
    int p;
    h = n / 2;
    if (kk == 0) return 1'b0;
    p = (kk - 1) % n;
    if (duty && ((n % 2) == 1)) return (p < h) || ((p == h) && (half == 1'b0));
    return p < h;
  endfunction

  task automatic push_exp(input bit half);
    sb_q.push_back({model(2, 1'b1, k, half), model(8, 1'b1, k, half),
                    model(7, 1'b0, k, half), model(7, 1'b1, k, half)});
  endtask

  task automatic pop_chk();
    logic [3:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("n7_duty50", co_d7, e[0]);
    chk("n7_rise",   co_n7, e[1]);
    chk("n8",        co_e8, e[2]);
    chk("n2",        co_n2, e[3]);
    chk("cnt_range", u_d7.r_cnt <= 3'd6, 1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) k++;
    push_exp(1'b0);
    #1 pop_chk();
    @(negedge clk);
    push_exp(1'b1);
    #1 pop_chk();
  endtask

  initial begin
    #1 rst_n = 1'b1;
    #1;
    chk("rst_d7", co_d7, 0);
    chk("rst_n7", co_n7, 0);
    chk("rst_e8", co_e8, 0);
    chk("rst_n2", co_n2, 0);
    repeat (3) step();

    rst_n = 1'b0;
    for (int i = 0; i < 84; i++) begin
      step();
      if (k == 8)  trans_base = trans;
      if (k == 78) chk("transitions_10_periods", trans - trans_base, 20);
    end

    // One more cycle puts the N=7 output in its high phase, then reset lands between edges.
    step();
    chk("pre_rst_high", co_d7, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rst_d7", co_d7, 0);
    chk("mid_rst_n7", co_n7, 0);
    chk("mid_rst_e8", co_e8, 0);
    chk("mid_rst_n2", co_n2, 0);
    k = 0;
    repeat (3) step();

    rst_n = 1'b0;
    repeat (30) step();
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/synch_mod_n_counter_7.md
# synch_mod_n_counter_7

Synchronous modulo-N counter clock divider, default N = 7. It produces a divided clock `clk_out` with period N input clock cycles. With the default 50% duty mode, the output for odd N is balanced by a falling-edge register. The block sits in the clock-divider library as the odd-ratio divider used to derive slow clocks from the system clock.

## Interface
Parameters:
- `N`, default 7: division ratio. Must be an integer ≥ 2. Any smaller value is an elaboration error.
- `DUTY_50`, default 1: 1 gives an exact 50% duty cycle for odd N using both clock edges. 0 gives a rising-edge-only output.
- `W`, default `$clog2(N)`: counter width. Derived from N; do not override.

Ports:
- `clk`, input, 1 bit: sole clock.
- `rst_n`, input, 1 bit: reset, asynchronous and active-high. Reset is asserted while `rst_n` = 1, despite the legacy name.
- `clk_out`, output, 1 bit: divided clock.

## Operation
- Counter `cnt` (W bits) advances on every `clk` rising edge outside reset.
  - It counts N-1 → 0 → 1 → … → N-1 → 0, and wraps at N-1.
  - `cnt` never holds a value ≥ N.
- Define H = floor(N/2); for N = 7, H = 3.
- `pos_q` is a rising-edge register. On each rising edge it loads (next `cnt` < H), so it is 1 while `cnt` ∈ [0, H-1].
- `neg_q` is a falling-edge register. On each falling edge of `clk` it loads `pos_q`.
- Output selection:
  - Odd N and DUTY_50 = 1: `clk_out = pos_q | neg_q`. The output is high for H + 0.5 cycles and low for H + 0.5 cycles.
  - Odd N and DUTY_50 = 0: `clk_out = pos_q`. The output is high for H cycles and low for N − H cycles; for N = 7 that is 3 high, 4 low.
  - Even N: `clk_out = pos_q` regardless of DUTY_50, giving an exact 50% duty cycle. `neg_q` is unused and may be optimized away.
- `clk_out` is driven only from registers through at most one OR gate. No other combinational path from `cnt` to the output is allowed.
- Reset, asynchronous on assertion:
  - Sets `cnt` = N-1, `pos_q` = 0, `neg_q` = 0, so `clk_out` = 0 immediately.
  - Applies regardless of clock state, including mid-period. No partial pulse continues after assertion.
- Reset release:
  - Deassertion is taken synchronously by the design: the first rising edge after release is the first counting edge.
  - On that edge `cnt` goes N-1 → 0 and `clk_out` rises, giving a full-length first high phase.

## Timing
- Latency: `clk_out` rises on rising edge 1 after reset release, i.e. within one cycle.
- Subsequent rising edges of `clk_out` occur at rising edges 1 + kN.
- Fall times, measured from edge 1 at N = 7:
  - DUTY_50 = 0: falls at rising edge 4, so high for 3 cycles.
  - DUTY_50 = 1: falls at the falling edge between rising edges 4 and 5, so high for 3.5 cycles.
- Output period is exactly N `clk` periods in steady state.
- With a 10 ns `clk` and N = 7, the period is 70 ns and the high time is 35 ns (DUTY_50 = 1) or 30 ns (DUTY_50 = 0).
- Wrap-around: the cycle where `cnt` goes N-1 → 0 is the `clk_out` rising edge. There is no glitch at wrap.
  - With DUTY_50 = 1, `neg_q` is 0 when `pos_q` rises, so the OR output has a single clean rise.
  - On the fall, `pos_q` falls while `neg_q` is 1, so the output falls only when `neg_q` falls.
- Reset mid-operation: `clk_out` goes to 0 with no clock needed. After release, the sequence restarts from edge 1 as above.
- The inputs satisfy recovery/removal timing relative to `clk`. The block contains no reset synchronizer.

## Test plan
- Default parameters, 10 ns `clk`, reset asserted then released at a falling edge:
  - `clk_out` = 0 during reset.
  - `clk_out` rises at the next rising edge.
  - `clk_out` stays high 35 ns and low 35 ns, repeating with a 70 ns period for ≥ 10 periods.
- DUTY_50 = 0, N = 7: `clk_out` is high 30 ns and low 40 ns, with rising edges exactly 70 ns apart.
- Reset asserted mid-high-phase, between clock edges:
  - `clk_out` drops to 0 with no clock edge and stays 0 while reset is held.
  - After release, the first rising edge gives a full 35 ns high phase.
- N = 8, DUTY_50 = 1: period 80 ns, high 40 ns, low 40 ns. `clk_out` changes only at `clk` rising edges.
- N = 2, DUTY_50 = 1: `clk_out` toggles every rising edge, giving a 20 ns period with 50% duty.
- Glitch check, N = 7, DUTY_50 = 1: exactly 2 transitions of `clk_out` per 70 ns window. `cnt` never exceeds 6.
